// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the decoded control-word pipeline.
package ctrl_pipe_pkg;

    localparam int CTRL_W = 13;

    typedef struct packed {
        logic       alu_st;
        logic       mem_st;
        logic       shift_op;
        logic [1:0] mem_op;
        logic [1:0] esc_wr;
        logic [1:0] vec_wr;
        logic [3:0] alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline stage: valid + word flop with flush / hold / bubble / advance selection.
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int             W        = CTRL_W,
    parameter logic [W-1:0]   NOP_WORD = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         hold,
    input  logic         prev_hold,
    input  logic         prev_valid,
    input  logic [W-1:0] prev_word,
    output logic         valid,
    output logic [W-1:0] word
);

    logic         valid_q, valid_d;
    logic [W-1:0] word_q, word_d;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (flush) begin
            valid_d = 1'b0;
            word_d  = NOP_WORD;
        end else if (hold) begin
            valid_d = valid_q;
            word_d  = word_q;
        end else if (prev_hold) begin
            valid_d = 1'b0;
            word_d  = NOP_WORD;
        end else begin
            // Gating on prev_valid keeps NOP in invalid slots even when the source is raw input.
            valid_d = prev_valid;
            word_d  = prev_valid ? prev_word : NOP_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            word_q  <= NOP_WORD;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign valid = valid_q;
    assign word  = word_q;

endmodule

// File: rtl/ctrl_pipe_reg.sv
// Multi-stage control-word pipeline with per-stage stall/flush, valid tracking
// and a saturating count of cycles spent not ready.
module ctrl_pipe_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int           W        = CTRL_W,
    parameter int           DEPTH    = 2,
    parameter logic [W-1:0] NOP_WORD = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [W-1:0]                 in_word,
    input  logic [DEPTH-1:0]             stall,
    input  logic [DEPTH-1:0]             flush,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [W-1:0]                 out_word,
    output logic [DEPTH-1:0]             stage_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  stall_cnt
);

    localparam int OCC_W = $clog2(DEPTH+1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("ctrl_pipe_reg: DEPTH must be in 1..8");
    end

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] prev_hold;
    logic [DEPTH:0]   src_valid;
    logic [W-1:0]     src_word [DEPTH+1];
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    // A stall anywhere downstream freezes this stage as well.
    always_comb begin
        hold = '0;
        hold[DEPTH-1] = stall[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            hold[k] = stall[k] | hold[k+1];
        end
    end

    assign in_ready     = ~hold[0];
    assign src_valid[0] = in_valid;
    assign src_word[0]  = in_word;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign prev_hold[k] = 1'b0;
        end else begin : g_rest
            assign prev_hold[k] = hold[k-1];
        end

        ctrl_pipe_stage #(
            .W        (W),
            .NOP_WORD (NOP_WORD)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush[k]),
            .hold       (hold[k]),
            .prev_hold  (prev_hold[k]),
            .prev_valid (src_valid[k]),
            .prev_word  (src_word[k]),
            .valid      (src_valid[k+1]),
            .word       (src_word[k+1])
        );
    end

    assign stage_valid = src_valid[DEPTH:1];
    assign out_valid   = src_valid[DEPTH];
    assign out_word    = src_word[DEPTH];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(stage_valid[k]);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!in_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
